// File: rtl/ioctl_sdram_loader.sv
// ioctl_sdram_loader: packs IN_W-bit host download words into OUT_W-bit SDRAM
// writes. Each packed word goes out over a toggle req/ack handshake while the
// host is throttled with ioctl_wait. A trailing partial word is flushed with
// byte enables, committed bytes are counted, and host writes that arrive while
// the loader is busy are flagged.
module ioctl_sdram_loader #(
  parameter int unsigned IN_W         = 16,
  parameter int unsigned OUT_W        = 32,
  parameter int unsigned AW           = 25,
  parameter logic [5:0]  INDEX_LO     = 6'h00,
  parameter logic [5:0]  INDEX_HI     = 6'h01,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned REGION_SHIFT = 20
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ioctl_download,
  input  logic [7:0]         ioctl_index,
  input  logic               ioctl_wr,
  input  logic [IN_W-1:0]    ioctl_dout,
  output logic               ioctl_wait,
  output logic [AW-1:0]      mem_waddr,
  output logic [OUT_W-1:0]   mem_din,
  output logic [OUT_W/8-1:0] mem_be,
  output logic               mem_we_req,
  input  logic               mem_we_ack,
  output logic               active,
  output logic               done,
  output logic [AW-1:0]      byte_count,
  output logic               proto_err
);

  localparam int unsigned N    = OUT_W / IN_W;
  localparam int unsigned BPW  = IN_W / 8;
  localparam int unsigned BEW  = OUT_W / 8;
  localparam logic [5:0]  SPAN = INDEX_HI - INDEX_LO;
  localparam logic [2:0]  LANE_LAST = 3'(N - 1);
  localparam logic [2:0]  LANE_END  = 3'(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WRITE,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state_q;
  logic              sel_q;
  logic [2:0]        lane_q;
  logic [2:0]        fill_lane_q;
  logic              flush_q;
  logic [OUT_W-1:0]  din_q;
  logic [BEW-1:0]    be_q;
  logic [AW-1:0]     waddr_q;
  logic [AW-1:0]     bc_q;
  logic [7:0]        commit_q;
  logic              req_q;
  logic              wait_q;
  logic              active_q;
  logic              done_q;
  logic              err_q;

  logic [5:0]        idx_off_c;
  logic              sel_c;
  logic              sel_rise_c;
  logic [AW-1:0]     region_base_c;
  logic [OUT_W-1:0]  din_in_c;
  logic [OUT_W-1:0]  din_flush_c;
  logic [7:0]        flush_bytes_c;
  logic [BEW-1:0]    flush_be_c;
  logic [AW:0]       bc_sum_c;
  logic [AW-1:0]     bc_next_c;
  logic              unused_idx_hi;

  assign unused_idx_hi = ^ioctl_index[7:6];

  // Index window test uses a wrapped offset so one compare covers both bounds.
  always_comb begin
    idx_off_c     = ioctl_index[5:0] - INDEX_LO;
    sel_c         = ioctl_download & (idx_off_c <= SPAN);
    sel_rise_c    = sel_c & ~sel_q;
    region_base_c = AW'(BASE_ADDR) + (AW'(idx_off_c) << REGION_SHIFT);
    // Shift forms keep N = 1 legal (no reversed part-select).
    din_in_c      = (OUT_W'(ioctl_dout) << (OUT_W - IN_W)) | (din_q >> IN_W);
    din_flush_c   = din_q >> IN_W;
    flush_bytes_c = 8'(fill_lane_q) * 8'(BPW);
    flush_be_c    = '0;
    for (int unsigned i = 0; i < BEW; i++) begin
      flush_be_c[i] = (8'(i) < flush_bytes_c);
    end
    bc_sum_c  = {1'b0, bc_q} + (AW+1)'(commit_q);
    bc_next_c = bc_sum_c[AW] ? '1 : bc_sum_c[AW-1:0];
  end

  // Loader FSM: packing, handshake, flush, completion and error tracking.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      lane_q      <= '0;
      fill_lane_q <= '0;
      flush_q     <= 1'b0;
      din_q       <= '0;
      be_q        <= '0;
      waddr_q     <= '0;
      bc_q        <= '0;
      commit_q    <= '0;
      req_q       <= mem_we_ack;
      wait_q      <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sel_q  <= sel_c;
      done_q <= 1'b0;
      if (ioctl_wr && (state_q == S_WRITE || state_q == S_FLUSH)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (sel_rise_c) begin
            lane_q   <= '0;
            waddr_q  <= region_base_c;
            bc_q     <= '0;
            active_q <= 1'b1;
            state_q  <= S_FILL;
          end
        end
        S_FILL: begin
          // Level test on sel also catches a drop that happened during WRITE.
          if (!sel_c) begin
            if (lane_q == '0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              fill_lane_q <= lane_q;
              state_q     <= S_FLUSH;
            end
          end else if (ioctl_wr) begin
            din_q <= din_in_c;
            if (lane_q == LANE_LAST) begin
              be_q     <= '1;
              commit_q <= 8'(BEW);
              req_q    <= ~req_q;
              wait_q   <= 1'b1;
              flush_q  <= 1'b0;
              state_q  <= S_WRITE;
            end else begin
              lane_q <= lane_q + 3'd1;
            end
          end
        end
        S_WRITE: begin
          if (mem_we_ack == req_q) begin
            wait_q  <= 1'b0;
            waddr_q <= waddr_q + AW'(BEW);
            bc_q    <= bc_next_c;
            lane_q  <= '0;
            if (flush_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_FILL;
            end
          end
        end
        S_FLUSH: begin
          if (lane_q == LANE_END) begin
            be_q     <= flush_be_c;
            commit_q <= flush_bytes_c;
            req_q    <= ~req_q;
            flush_q  <= 1'b1;
            state_q  <= S_WRITE;
          end else begin
            din_q  <= din_flush_c;
            lane_q <= lane_q + 3'd1;
          end
        end
        S_DONE: begin
          active_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ioctl_wait = wait_q;
  assign mem_waddr  = waddr_q;
  assign mem_din    = din_q;
  assign mem_be     = be_q;
  assign mem_we_req = req_q;
  assign active     = active_q;
  assign done       = done_q;
  assign byte_count = bc_q;
  assign proto_err  = err_q;

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Testbench for ioctl_sdram_loader: table of download transactions on a
// 16->32 instance with a delayed-ack SDRAM responder, plus hand sequences for
// an 8->32 instance, protocol errors and reset mid-write.
module tb_ioctl_sdram_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        dl16, wr16, wait16, req16, ack16, act16, done16, err16;
  logic [7:0]  idx16;
  logic [15:0] dout16;
  logic [24:0] waddr16, bc16;
  logic [31:0] din16;
  logic [3:0]  be16;

  logic        dl8, wr8, wait8, req8, ack8, act8, done8, err8;
  logic [7:0]  idx8;
  logic [7:0]  dout8;
  logic [24:0] waddr8, bc8;
  logic [31:0] din8;
  logic [3:0]  be8;

  ioctl_sdram_loader #(
    .IN_W(16), .OUT_W(32), .AW(25), .INDEX_LO(6'h00), .INDEX_HI(6'h01),
    .BASE_ADDR(0), .REGION_SHIFT(20)
  ) dut16 (
    .clk_sys(clk), .reset(reset), .ioctl_download(dl16), .ioctl_index(idx16),
    .ioctl_wr(wr16), .ioctl_dout(dout16), .ioctl_wait(wait16),
    .mem_waddr(waddr16), .mem_din(din16), .mem_be(be16), .mem_we_req(req16),
    .mem_we_ack(ack16), .active(act16), .done(done16), .byte_count(bc16),
    .proto_err(err16)
  );

  ioctl_sdram_loader #(
    .IN_W(8), .OUT_W(32), .AW(25), .INDEX_LO(6'h00), .INDEX_HI(6'h01),
    .BASE_ADDR(0), .REGION_SHIFT(20)
  ) dut8 (
    .clk_sys(clk), .reset(reset), .ioctl_download(dl8), .ioctl_index(idx8),
    .ioctl_wr(wr8), .ioctl_dout(dout8), .ioctl_wait(wait8),
    .mem_waddr(waddr8), .mem_din(din8), .mem_be(be8), .mem_we_req(req8),
    .mem_we_ack(ack8), .active(act8), .done(done8), .byte_count(bc8),
    .proto_err(err8)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SDRAM write log, filled by the responder when it acknowledges.
  logic [24:0] log_addr[$];
  logic [31:0] log_din[$];
  logic [3:0]  log_be[$];

  int unsigned ack_delay = 0;
  logic        pend;
  int unsigned pcnt;

  // Responder: once a req edge is seen, ack toggles d cycles later regardless
  // of what req does meanwhile (models a controller completing after reset).
  initial begin
    ack16 = 1'b0;
    pend  = 1'b0;
    pcnt  = 0;
    forever begin
      @(posedge clk); #1;
      if (!pend && (req16 != ack16)) begin
        pend = 1'b1;
        pcnt = 0;
      end
      if (pend) begin
        if (pcnt >= ack_delay) begin
          log_addr.push_back(waddr16);
          log_din.push_back(din16);
          log_be.push_back(be16);
          ack16 = ~ack16;
          pend  = 1'b0;
        end else begin
          pcnt++;
        end
      end
    end
  end

  logic act_seen;
  int   done_cnt;
  int   done8_cnt;

  task automatic tick();
    @(posedge clk); #1;
    if (act16) act_seen = 1'b1;
    if (done16) done_cnt++;
    if (done8) done8_cnt++;
  endtask

  task automatic wait_low16();
    int n = 0;
    while (wait16 && n < 60) begin
      tick();
      n++;
    end
    if (wait16) begin
      checks++;
      errors++;
      $display("FAIL wait16_timeout: ioctl_wait=1 after 60 cycles, expected 0");
    end
  endtask

  task automatic send16(input logic [15:0] data);
    wait_low16();
    wr16   = 1'b1;
    dout16 = data;
    tick();
    wr16   = 1'b0;
  endtask

  task automatic send8(input logic [7:0] data);
    wr8   = 1'b1;
    dout8 = data;
    tick();
    wr8   = 1'b0;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_din.delete();
    log_be.delete();
    act_seen = 1'b0;
    done_cnt = 0;
  endtask

  task automatic run_dl(input logic [5:0] idx, input int unsigned nw,
                        input logic [15:0] w0, input logic [15:0] step,
                        input int unsigned dly);
    logic [15:0] w;
    clear_log();
    ack_delay = dly;
    idx16 = {2'b00, idx};
    dl16  = 1'b1;
    tick();
    w = w0;
    for (int unsigned k = 0; k < nw; k++) begin
      send16(w);
      w = w + step;
    end
    wait_low16();
    dl16 = 1'b0;
    repeat (30) tick();
  endtask

  typedef struct {
    logic [5:0]  idx;
    int unsigned nw;
    logic [15:0] w0;
    logic [15:0] step;
    int unsigned dly;
    int unsigned exp_writes;
    logic [24:0] exp_first;
    logic [24:0] exp_last;
    logic [31:0] exp_din;
    logic [3:0]  exp_be;
    logic [24:0] exp_bc;
    int unsigned exp_done;
    logic        exp_active;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   nedge;
    logic r0;

    vecs[0] = '{6'd0, 2, 16'h1111, 16'h1111, 0, 1, 25'h0,       25'h0,       32'h22221111, 4'hF, 25'd4,  1, 1'b1};
    vecs[1] = '{6'd0, 5, 16'h0001, 16'h0001, 3, 3, 25'h0,       25'h8,       32'h00000005, 4'h3, 25'd10, 1, 1'b1};
    vecs[2] = '{6'd1, 2, 16'hA5A5, 16'h0101, 0, 1, 25'h100000,  25'h100000,  32'hA6A6A5A5, 4'hF, 25'd4,  1, 1'b1};
    vecs[3] = '{6'd2, 2, 16'h7777, 16'h0001, 0, 0, 25'h0,       25'h0,       32'h0,        4'h0, 25'd4,  0, 1'b0};
    vecs[4] = '{6'd1, 3, 16'h1234, 16'h1111, 1, 2, 25'h100000,  25'h100004,  32'h00003456, 4'h3, 25'd6,  1, 1'b1};
    vecs[5] = '{6'd0, 0, 16'h0000, 16'h0000, 0, 0, 25'h0,       25'h0,       32'h0,        4'h0, 25'd0,  1, 1'b1};
    vecs[6] = '{6'd0, 4, 16'h0010, 16'h0010, 2, 2, 25'h0,       25'h4,       32'h00400030, 4'hF, 25'd8,  1, 1'b1};

    reset = 1'b1;
    dl16 = 1'b0; idx16 = '0; wr16 = 1'b0; dout16 = '0;
    dl8  = 1'b0; idx8  = '0; wr8  = 1'b0; dout8  = '0; ack8 = 1'b0;
    act_seen = 1'b0; done_cnt = 0; done8_cnt = 0;
    repeat (4) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_wait", wait16, 0);
    chk("rst_active", act16, 0);
    chk("rst_done", done16, 0);
    chk("rst_err", err16, 0);
    chk("rst_bc", bc16, 0);
    chk("rst_waddr", waddr16, 0);
    chk("rst_din", din16, 0);
    chk("rst_be", be16, 0);
    chk("rst_req_sync", req16, ack16);
    chk("rst8_req_sync", req8, ack8);
    chk("rst8_active", act8, 0);
    tick();

    // Table-driven downloads on the 16->32 instance
    for (int i = 0; i < 7; i++) begin
      run_dl(vecs[i].idx, vecs[i].nw, vecs[i].w0, vecs[i].step, vecs[i].dly);
      chk($sformatf("v%0d_writes", i), 64'(log_addr.size()), 64'(vecs[i].exp_writes));
      if (vecs[i].exp_writes > 0 && log_addr.size() > 0) begin
        chk($sformatf("v%0d_first_addr", i), log_addr[0], vecs[i].exp_first);
        chk($sformatf("v%0d_last_addr", i), log_addr[log_addr.size()-1], vecs[i].exp_last);
        chk($sformatf("v%0d_last_din", i), log_din[log_din.size()-1], vecs[i].exp_din);
        chk($sformatf("v%0d_last_be", i), log_be[log_be.size()-1], vecs[i].exp_be);
      end
      chk($sformatf("v%0d_byte_count", i), bc16, vecs[i].exp_bc);
      chk($sformatf("v%0d_done_pulses", i), 64'(done_cnt), 64'(vecs[i].exp_done));
      chk($sformatf("v%0d_active_seen", i), act_seen, vecs[i].exp_active);
      chk($sformatf("v%0d_active_end", i), act16, 0);
    end
    chk("err_clean", err16, 0);

    // 8->32 packing with ack held off for 7 cycles
    idx8 = 8'h00;
    dl8  = 1'b1;
    tick();
    send8(8'hAA);
    send8(8'hBB);
    send8(8'hCC);
    send8(8'hDD);
    chk("w8_req_pending", req8 ^ ack8, 1);
    chk("w8_wait_rise", wait8, 1);
    chk("w8_din", din8, 32'hDDCCBBAA);
    chk("w8_be", be8, 4'hF);
    chk("w8_waddr", waddr8, 0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("w8_wait_hold%0d", k), wait8, 1);
    end
    chk("w8_din_stable", din8, 32'hDDCCBBAA);
    ack8 = req8;
    tick();
    chk("w8_wait_fall", wait8, 0);
    dl8 = 1'b0;
    done8_cnt = 0;
    repeat (10) tick();
    chk("w8_done", 64'(done8_cnt), 1);
    chk("w8_bc", bc8, 4);
    chk("w8_waddr_next", waddr8, 4);

    // ioctl_wr during WRITE is dropped and flagged
    clear_log();
    ack_delay = 4;
    idx16 = 8'h00;
    dl16  = 1'b1;
    tick();
    send16(16'h1111);
    send16(16'h2222);
    chk("pe_wait_high", wait16, 1);
    wr16 = 1'b1; dout16 = 16'h9999;
    tick();
    wr16 = 1'b0;
    chk("pe_flag", err16, 1);
    send16(16'h3333);
    send16(16'h4444);
    wait_low16();
    dl16 = 1'b0;
    repeat (30) tick();
    chk("pe_writes", 64'(log_din.size()), 2);
    if (log_din.size() == 2) begin
      chk("pe_din0", log_din[0], 32'h22221111);
      chk("pe_din1", log_din[1], 32'h44443333);
      chk("pe_addr1", log_addr[1], 4);
    end
    chk("pe_bc", bc16, 8);
    chk("pe_sticky", err16, 1);

    // Reset mid-WRITE while ack lags; ack completes during reset
    clear_log();
    ack_delay = 5;
    idx16 = 8'h00;
    dl16  = 1'b1;
    tick();
    send16(16'h5555);
    send16(16'h6666);
    chk("rw_wait_high", wait16, 1);
    tick();
    reset = 1'b1;
    dl16  = 1'b0;
    repeat (9) tick();
    reset = 1'b0;
    chk("rw_req_sync", req16, ack16);
    r0 = req16;
    nedge = 0;
    repeat (6) begin
      tick();
      if (req16 != r0) nedge++;
    end
    chk("rw_no_req_edge", 64'(nedge), 0);
    chk("rw_err_cleared", err16, 0);
    chk("rw_bc", bc16, 0);
    chk("rw_active", act16, 0);
    chk("rw_wait", wait16, 0);
    chk("rw_waddr", waddr16, 0);
    run_dl(6'd0, 2, 16'h1000, 16'h1000, 0);
    chk("rw_next_writes", 64'(log_din.size()), 1);
    if (log_din.size() == 1) begin
      chk("rw_next_addr", log_addr[0], 0);
      chk("rw_next_din", log_din[0], 32'h20001000);
    end
    chk("rw_next_bc", bc16, 4);
    chk("rw_next_done", 64'(done_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
